// File: rtl/ad7606_par_ctrl_if.sv
// rtl/ad7606_par_ctrl_if.sv - ADC pin and channel-stream bundle for ad7606_par_ctrl
interface ad7606_par_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              en;
    logic [2:0]        os_sel;
    logic [DATA_W-1:0] ad_data;
    logic              ad_busy;
    logic              first_data;
    logic [2:0]        ad_os;
    logic              ad_cs;
    logic              ad_rd;
    logic              ad_reset;
    logic              ad_convst;
    logic [DATA_W-1:0] ch_data;
    logic [2:0]        ch_idx;
    logic              ch_valid;
    logic              frame_done;
    logic              overrun;
    logic              busy_err;
    logic              sync_err;

    // Controller side
    modport master (
        input  en, os_sel, ad_data, ad_busy, first_data,
        output ad_os, ad_cs, ad_rd, ad_reset, ad_convst,
        output ch_data, ch_idx, ch_valid, frame_done, overrun, busy_err, sync_err
    );

    // ADC / datapath side
    modport slave (
        output en, os_sel, ad_data, ad_busy, first_data,
        input  ad_os, ad_cs, ad_rd, ad_reset, ad_convst,
        input  ch_data, ch_idx, ch_valid, frame_done, overrun, busy_err, sync_err
    );
endinterface

// File: rtl/ad7606_par_ctrl.sv
// rtl/ad7606_par_ctrl.sv - AD7606 parallel-bus controller; AD_FIRSTDATA_CHK_EN enables FRSTDATA checking
module ad7606_par_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 16,
    parameter int RST_CYC    = 4,
    parameter int CONV_LO    = 2,
    parameter int WAIT_HI    = 5,
    parameter int RD_LO      = 3,
    parameter int RD_HI      = 1,
    parameter int SAMPLE_DIV = 1000,
    parameter int BUSY_TMO   = 4000
) (
    input  logic              clk,
    input  logic              rst_n,
    ad7606_par_ctrl_if.master bus
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared phase counter serves every timed state, so it must hold the longest one.
    localparam int CNT_MAX = max_of(max_of(max_of(RST_CYC, CONV_LO), max_of(WAIT_HI, RD_LO)),
                                    max_of(RD_HI, BUSY_TMO));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {
        PWR_RST,
        IDLE,
        CONV,
        WAIT_H,
        WAIT_BUSY,
        RD_L,
        RD_H,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        ch_q, ch_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              tick_q, tick_d;

    logic              ad_reset_q, ad_reset_d;
    logic              ad_cs_q, ad_cs_d;
    logic              ad_rd_q, ad_rd_d;
    logic              ad_convst_q, ad_convst_d;
    logic [2:0]        ad_os_q, ad_os_d;
    logic [DATA_W-1:0] ch_data_q, ch_data_d;
    logic [2:0]        ch_idx_q, ch_idx_d;
    logic              ch_valid_q, ch_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              busy_err_q, busy_err_d;
    logic              sync_err_q, sync_err_d;

    function automatic logic cnt_last(input logic [CNT_W-1:0] c, input int n);
        return c == CNT_W'(n - 1);
    endfunction

`ifndef AD_FIRSTDATA_CHK_EN
    logic unused_first_data;
    assign unused_first_data = bus.first_data;
`endif

    // Free-running frame timer; tick is high for the one cycle after the count wraps to 0.
    always_comb begin
        tmr_d  = tmr_q + TMR_W'(1);
        tick_d = 1'b0;
        if (tmr_q == TMR_W'(SAMPLE_DIV - 1)) begin
            tmr_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Next-state, capture and pulse logic; pin levels are decoded from the next state so they register cleanly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        ad_os_d      = ad_os_q;
        ch_data_d    = ch_data_q;
        ch_idx_d     = ch_idx_q;
        ch_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        busy_err_d   = 1'b0;
        sync_err_d   = 1'b0;
        overrun_d    = tick_q && (state_q != IDLE);

        case (state_q)
            PWR_RST: begin
                if (cnt_last(cnt_q, RST_CYC)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                ad_os_d = bus.os_sel;
                if (tick_q && bus.en) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                if (cnt_last(cnt_q, CONV_LO)) begin
                    state_d = WAIT_H;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_H: begin
                if (cnt_last(cnt_q, WAIT_HI)) begin
                    state_d = WAIT_BUSY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_BUSY: begin
                if (!bus.ad_busy) begin
                    state_d = RD_L;
                    cnt_d   = '0;
                    ch_d    = '0;
                end else if (cnt_last(cnt_q, BUSY_TMO)) begin
                    busy_err_d = 1'b1;
                    state_d    = PWR_RST;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_L: begin
                if (cnt_last(cnt_q, RD_LO)) begin
                    ch_data_d  = bus.ad_data;
                    ch_idx_d   = ch_q;
                    ch_valid_d = 1'b1;
                    cnt_d      = '0;
`ifdef AD_FIRSTDATA_CHK_EN
                    // FRSTDATA must be high exactly on channel 0; otherwise the frame is out of step.
                    if (bus.first_data != (ch_q == 3'd0)) begin
                        sync_err_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = RD_H;
                    end
`else
                    state_d = RD_H;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_H: begin
                if (cnt_last(cnt_q, RD_HI)) begin
                    cnt_d = '0;
                    if (ch_q == 3'(NUM_CH - 1)) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        state_d = RD_L;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = PWR_RST;
                cnt_d   = '0;
            end
        endcase

        ad_reset_d  = (state_d == PWR_RST);
        ad_cs_d     = !((state_d == RD_L) || (state_d == RD_H));
        ad_rd_d     = (state_d != RD_L);
        ad_convst_d = (state_d != CONV);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PWR_RST;
            cnt_q        <= '0;
            ch_q         <= '0;
            tmr_q        <= '0;
            tick_q       <= 1'b0;
            ad_reset_q   <= 1'b1;
            ad_cs_q      <= 1'b1;
            ad_rd_q      <= 1'b1;
            ad_convst_q  <= 1'b1;
            ad_os_q      <= '0;
            ch_data_q    <= '0;
            ch_idx_q     <= '0;
            ch_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_err_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            tmr_q        <= tmr_d;
            tick_q       <= tick_d;
            ad_reset_q   <= ad_reset_d;
            ad_cs_q      <= ad_cs_d;
            ad_rd_q      <= ad_rd_d;
            ad_convst_q  <= ad_convst_d;
            ad_os_q      <= ad_os_d;
            ch_data_q    <= ch_data_d;
            ch_idx_q     <= ch_idx_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            busy_err_q   <= busy_err_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign bus.ad_reset   = ad_reset_q;
    assign bus.ad_cs      = ad_cs_q;
    assign bus.ad_rd      = ad_rd_q;
    assign bus.ad_convst  = ad_convst_q;
    assign bus.ad_os      = ad_os_q;
    assign bus.ch_data    = ch_data_q;
    assign bus.ch_idx     = ch_idx_q;
    assign bus.ch_valid   = ch_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy_err   = busy_err_q;
    assign bus.sync_err   = sync_err_q;

endmodule
